// File: rtl/parking_gate_ctrl_p_pkg.sv
// Shared definitions for the parking entrance gate controller.
// Holds the FSM state encoding and the factory PIN.
package gate_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_PIN = 2'd1,
        OPEN     = 2'd2,
        BLOCK    = 2'd3
    } gateState_t;

    localparam logic [7:0] PIN_DEFAULT = 8'b0011_1000;

    // True when a candidate code equals the configured PIN.
    function automatic logic pinMatch(input logic [31:0] code, input logic [31:0] pin);
        return (code == pin);
    endfunction

endpackage

// File: rtl/parking_gate_ctrl_p_if.sv
// Sensor/keypad inputs and actuator/alarm outputs of the entrance gate.
// The controller connects through the slave modport, the stimulus side through master.
interface parking_gate_ctrl_p_if #(
    parameter int PIN_W  = 8,
    parameter int OCC_W  = 5,
    parameter int FAIL_W = 2
);
    logic              sEntrada;
    logic              sSalida;
    logic              sEnter;
    logic [PIN_W-1:0]  sCode;
    logic              sVehSale;
    logic              sAbrir;
    logic              sCerrar;
    logic              sBloq;
    logic              sAlmInc;
    logic              sAlmBloq;
    logic              sFull;
    logic [OCC_W-1:0]  occ;
    logic [FAIL_W-1:0] fail_cnt;

    modport master (
        output sEntrada, sSalida, sEnter, sCode, sVehSale,
        input  sAbrir, sCerrar, sBloq, sAlmInc, sAlmBloq, sFull, occ, fail_cnt
    );

    modport slave (
        input  sEntrada, sSalida, sEnter, sCode, sVehSale,
        output sAbrir, sCerrar, sBloq, sAlmInc, sAlmBloq, sFull, occ, fail_cnt
    );
endinterface

// File: rtl/parking_gate_ctrl_p_gate_occ_counter.sv
// Saturating up/down lot occupancy counter with a registered full flag.
// Simultaneous entry and exit strobes cancel out.
module gate_occ_counter #(
    parameter int CAP   = 16,
    parameter int OCC_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             incPulse,
    input  logic             decPulse,
    output logic [OCC_W-1:0] occ,
    output logic             full
);
    localparam logic [OCC_W-1:0] CAP_V  = OCC_W'(CAP);
    localparam logic [OCC_W-1:0] ZERO_V = OCC_W'(0);
    localparam logic [OCC_W-1:0] ONE_V  = OCC_W'(1);

    logic [OCC_W-1:0] occR;
    logic [OCC_W-1:0] occS;
    logic             fullR;

    // Next occupancy with saturation at both ends.
    always_comb begin
        occS = occR;
        if (incPulse && !decPulse) begin
            if (occR == CAP_V) begin
                occS = occR;
            end else begin
                occS = occR + ONE_V;
            end
        end else if (decPulse && !incPulse) begin
            if (occR == ZERO_V) begin
                occS = occR;
            end else begin
                occS = occR - ONE_V;
            end
        end else begin
            occS = occR;
        end
    end

    // Occupancy and full flag registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            occR  <= ZERO_V;
            fullR <= 1'b0;
        end else begin
            occR  <= occS;
            fullR <= (occS == CAP_V);
        end
    end

    assign occ  = occR;
    assign full = fullR;

endmodule

// File: rtl/parking_gate_ctrl_p.sv
// Parking entrance gate controller: PIN entry, open timeout, tailgating block
// and lot occupancy tracking. All outputs come straight from registers.
module parking_gate_ctrl_p
    import gate_pkg::*;
#(
    parameter int             PIN_W    = 8,
    parameter logic [PIN_W-1:0] PIN_OK = PIN_W'(PIN_DEFAULT),
    parameter int             MAX_FAIL = 3,
    parameter int             CAP      = 16,
    parameter int             OCC_W    = 5,
    parameter int             TMO_CYC  = 200
) (
    input logic                 clock,
    input logic                 reset,
    parking_gate_ctrl_p_if.slave gate
);
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);
    localparam int TMR_W  = $clog2(TMO_CYC);
    localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_FAIL);
    localparam logic [FAIL_W-1:0] FAIL_ZERO = FAIL_W'(0);
    localparam logic [FAIL_W-1:0] FAIL_ONE  = FAIL_W'(1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TMO_CYC - 1);
    localparam logic [TMR_W-1:0]  TMR_ZERO  = TMR_W'(0);
    localparam logic [TMR_W-1:0]  TMR_ONE   = TMR_W'(1);

    gateState_t        stateR, stateS;
    logic [TMR_W-1:0]  timerR, timerS;
    logic [FAIL_W-1:0] failR, failS, failSat;
    logic              almIncR, almIncS;
    logic              sEnterD, sSalidaD, sVehSaleD;
    logic              enterPulse, passPulse, leavePulse;
    logic              codeOk, occInc, fullS;
    logic              abrirR, cerrarR, bloqR, almBloqR;
    logic [OCC_W-1:0]  occS;

    assign enterPulse = gate.sEnter   & ~sEnterD;
    assign passPulse  = gate.sSalida  & ~sSalidaD;
    assign leavePulse = gate.sVehSale & ~sVehSaleD;
    assign codeOk     = pinMatch(32'(gate.sCode), 32'(PIN_OK));
    assign failSat    = (failR == FAIL_MAX) ? failR : (failR + FAIL_ONE);

    // Next-state, timer and wrong-PIN bookkeeping.
    always_comb begin
        stateS  = stateR;
        timerS  = timerR;
        failS   = failR;
        almIncS = almIncR;
        occInc  = 1'b0;
        case (stateR)
            IDLE: begin
                if (gate.sEntrada) begin
                    stateS = WAIT_PIN;
                end else begin
                    stateS = IDLE;
                end
            end
            WAIT_PIN: begin
                if (enterPulse && codeOk) begin
                    failS   = FAIL_ZERO;
                    almIncS = 1'b0;
                    if (!fullS) begin
                        stateS = OPEN;
                        timerS = TMR_ZERO;
                    end else begin
                        stateS = WAIT_PIN;
                    end
                end else if (enterPulse) begin
                    failS   = failSat;
                    almIncS = almIncR | (failSat == FAIL_MAX);
                    if (gate.sEntrada) begin
                        stateS = WAIT_PIN;
                    end else begin
                        stateS = IDLE;
                    end
                end else if (!gate.sEntrada) begin
                    stateS = IDLE;
                end else begin
                    stateS = WAIT_PIN;
                end
            end
            OPEN: begin
                // Two sensors active at once means a second car is tailgating.
                if (gate.sEntrada && gate.sSalida) begin
                    stateS = BLOCK;
                    timerS = TMR_ZERO;
                end else if (passPulse && !gate.sEntrada) begin
                    stateS = IDLE;
                    timerS = TMR_ZERO;
                    occInc = 1'b1;
                end else if (timerR == TMR_LAST) begin
                    stateS = IDLE;
                    timerS = TMR_ZERO;
                end else begin
                    stateS = OPEN;
                    timerS = timerR + TMR_ONE;
                end
            end
            BLOCK: begin
                // The car is already committed, so a full lot does not hold it here.
                if (enterPulse && codeOk) begin
                    stateS  = OPEN;
                    timerS  = TMR_ZERO;
                    failS   = FAIL_ZERO;
                    almIncS = 1'b0;
                end else if (enterPulse) begin
                    stateS  = BLOCK;
                    failS   = failSat;
                    almIncS = almIncR | (failSat == FAIL_MAX);
                end else begin
                    stateS = BLOCK;
                end
            end
            default: begin
                stateS = IDLE;
                timerS = TMR_ZERO;
            end
        endcase
    end

    // State, timer, edge detectors and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stateR    <= IDLE;
            timerR    <= TMR_ZERO;
            failR     <= FAIL_ZERO;
            almIncR   <= 1'b0;
            sEnterD   <= 1'b0;
            sSalidaD  <= 1'b0;
            sVehSaleD <= 1'b0;
            abrirR    <= 1'b0;
            cerrarR   <= 1'b1;
            bloqR     <= 1'b0;
            almBloqR  <= 1'b0;
        end else begin
            stateR    <= stateS;
            timerR    <= timerS;
            failR     <= failS;
            almIncR   <= almIncS;
            sEnterD   <= gate.sEnter;
            sSalidaD  <= gate.sSalida;
            sVehSaleD <= gate.sVehSale;
            abrirR    <= (stateS == OPEN);
            cerrarR   <= (stateS != OPEN);
            bloqR     <= (stateS == BLOCK);
            almBloqR  <= (stateS == BLOCK);
        end
    end

    gate_occ_counter #(
        .CAP   (CAP),
        .OCC_W (OCC_W)
    ) uOcc (
        .clock    (clock),
        .reset    (reset),
        .incPulse (occInc),
        .decPulse (leavePulse),
        .occ      (occS),
        .full     (fullS)
    );

    assign gate.sAbrir   = abrirR;
    assign gate.sCerrar  = cerrarR;
    assign gate.sBloq    = bloqR;
    assign gate.sAlmInc  = almIncR;
    assign gate.sAlmBloq = almBloqR;
    assign gate.sFull    = fullS;
    assign gate.occ      = occS;
    assign gate.fail_cnt = failR;

endmodule

// File: tb/tb_parking_gate_ctrl_p.sv
// Directed bench: vector table on a default-parameter gate, plus hand-written
// capacity, timeout and mid-open reset sequences on a CAP=2 / TMO_CYC=8 gate.
module tb_parking_gate_ctrl_p;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    parking_gate_ctrl_p_if #(.PIN_W(8), .OCC_W(5), .FAIL_W(2)) busA ();
    parking_gate_ctrl_p_if #(.PIN_W(8), .OCC_W(2), .FAIL_W(2)) busB ();

    parking_gate_ctrl_p dutA (
        .clock (clock),
        .reset (reset),
        .gate  (busA)
    );

    parking_gate_ctrl_p #(.CAP(2), .OCC_W(2), .TMO_CYC(8)) dutB (
        .clock (clock),
        .reset (reset),
        .gate  (busB)
    );

    typedef struct {
        logic       ent, sal, en, veh;
        logic [7:0] code;
        logic       ab, bl, ai, full;
        logic [4:0] occ;
        logic [1:0] fail;
    } vecT;

    vecT vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic addVec(input logic ent, input logic sal, input logic en, input logic veh,
                          input logic [7:0] code, input logic ab, input logic bl, input logic ai,
                          input logic full, input logic [4:0] occ, input logic [1:0] fail);
        vecT v;
        v.ent = ent; v.sal = sal; v.en = en; v.veh = veh; v.code = code;
        v.ab = ab; v.bl = bl; v.ai = ai; v.full = full; v.occ = occ; v.fail = fail;
        vecs.push_back(v);
    endtask

    task automatic stepB(input logic ent, input logic sal, input logic en, input logic veh,
                         input logic [7:0] code);
        busB.sEntrada = ent;
        busB.sSalida  = sal;
        busB.sEnter   = en;
        busB.sVehSale = veh;
        busB.sCode    = code;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [12:0] packA();
        return {busA.sAbrir, busA.sCerrar, busA.sBloq, busA.sAlmBloq, busA.sAlmInc,
                busA.sFull, busA.occ, busA.fail_cnt};
    endfunction

    function automatic logic [9:0] packB();
        return {busB.sAbrir, busB.sCerrar, busB.sBloq, busB.sAlmBloq, busB.sAlmInc,
                busB.sFull, busB.occ, busB.fail_cnt};
    endfunction

    initial begin
        busA.sEntrada = 1'b0; busA.sSalida = 1'b0; busA.sEnter = 1'b0;
        busA.sVehSale = 1'b0; busA.sCode = 8'h00;
        busB.sEntrada = 1'b0; busB.sSalida = 1'b0; busB.sEnter = 1'b0;
        busB.sVehSale = 1'b0; busB.sCode = 8'h00;

        //      ent  sal  en   veh  code   ab   bl   ai   full occ    fail
        // normal entry
        addVec(1'b1,1'b0,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b0,5'd0, 2'd0);
        addVec(1'b1,1'b0,1'b1,1'b0,8'h38, 1'b1,1'b0,1'b0,1'b0,5'd0, 2'd0);
        addVec(1'b0,1'b1,1'b0,1'b0,8'h38, 1'b0,1'b0,1'b0,1'b0,5'd1, 2'd0);
        addVec(1'b0,1'b0,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b0,5'd1, 2'd0);
        // two wrong PINs then correct
        addVec(1'b1,1'b0,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b0,5'd1, 2'd0);
        addVec(1'b1,1'b0,1'b1,1'b0,8'hDA, 1'b0,1'b0,1'b0,1'b0,5'd1, 2'd1);
        addVec(1'b1,1'b0,1'b0,1'b0,8'hDA, 1'b0,1'b0,1'b0,1'b0,5'd1, 2'd1);
        addVec(1'b1,1'b0,1'b1,1'b0,8'h0F, 1'b0,1'b0,1'b0,1'b0,5'd1, 2'd2);
        addVec(1'b1,1'b0,1'b0,1'b0,8'h0F, 1'b0,1'b0,1'b0,1'b0,5'd1, 2'd2);
        addVec(1'b1,1'b0,1'b1,1'b0,8'h38, 1'b1,1'b0,1'b0,1'b0,5'd1, 2'd0);
        addVec(1'b0,1'b1,1'b0,1'b0,8'h38, 1'b0,1'b0,1'b0,1'b0,5'd2, 2'd0);
        addVec(1'b0,1'b0,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b0,5'd2, 2'd0);
        // four wrong PINs, alarm, saturation, then correct
        addVec(1'b1,1'b0,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b0,5'd2, 2'd0);
        addVec(1'b1,1'b0,1'b1,1'b0,8'h56, 1'b0,1'b0,1'b0,1'b0,5'd2, 2'd1);
        addVec(1'b1,1'b0,1'b0,1'b0,8'h56, 1'b0,1'b0,1'b0,1'b0,5'd2, 2'd1);
        addVec(1'b1,1'b0,1'b1,1'b0,8'h6E, 1'b0,1'b0,1'b0,1'b0,5'd2, 2'd2);
        addVec(1'b1,1'b0,1'b0,1'b0,8'h6E, 1'b0,1'b0,1'b0,1'b0,5'd2, 2'd2);
        addVec(1'b1,1'b0,1'b1,1'b0,8'hFF, 1'b0,1'b0,1'b1,1'b0,5'd2, 2'd3);
        addVec(1'b1,1'b0,1'b0,1'b0,8'hFF, 1'b0,1'b0,1'b1,1'b0,5'd2, 2'd3);
        addVec(1'b1,1'b0,1'b1,1'b0,8'h01, 1'b0,1'b0,1'b1,1'b0,5'd2, 2'd3);
        addVec(1'b1,1'b0,1'b0,1'b0,8'h01, 1'b0,1'b0,1'b1,1'b0,5'd2, 2'd3);
        addVec(1'b1,1'b0,1'b1,1'b0,8'h38, 1'b1,1'b0,1'b0,1'b0,5'd2, 2'd0);
        // tailgate block, wrong PIN holds it, correct PIN reopens, pass
        addVec(1'b1,1'b1,1'b0,1'b0,8'h38, 1'b0,1'b1,1'b0,1'b0,5'd2, 2'd0);
        addVec(1'b0,1'b0,1'b0,1'b0,8'h38, 1'b0,1'b1,1'b0,1'b0,5'd2, 2'd0);
        addVec(1'b0,1'b0,1'b1,1'b0,8'h7D, 1'b0,1'b1,1'b0,1'b0,5'd2, 2'd1);
        addVec(1'b0,1'b0,1'b0,1'b0,8'h7D, 1'b0,1'b1,1'b0,1'b0,5'd2, 2'd1);
        addVec(1'b0,1'b0,1'b1,1'b0,8'h38, 1'b1,1'b0,1'b0,1'b0,5'd2, 2'd0);
        addVec(1'b0,1'b1,1'b0,1'b0,8'h38, 1'b0,1'b0,1'b0,1'b0,5'd3, 2'd0);
        addVec(1'b0,1'b0,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b0,5'd3, 2'd0);
        // exit lane: one decrement per rising edge
        addVec(1'b0,1'b0,1'b0,1'b1,8'h00, 1'b0,1'b0,1'b0,1'b0,5'd2, 2'd0);
        addVec(1'b0,1'b0,1'b0,1'b1,8'h00, 1'b0,1'b0,1'b0,1'b0,5'd2, 2'd0);
        addVec(1'b0,1'b0,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b0,5'd2, 2'd0);
        // same-cycle pass and exit cancel
        addVec(1'b1,1'b0,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b0,5'd2, 2'd0);
        addVec(1'b1,1'b0,1'b1,1'b0,8'h38, 1'b1,1'b0,1'b0,1'b0,5'd2, 2'd0);
        addVec(1'b0,1'b1,1'b0,1'b1,8'h38, 1'b0,1'b0,1'b0,1'b0,5'd2, 2'd0);
        addVec(1'b0,1'b0,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b0,5'd2, 2'd0);
        // PIN in IDLE ignored; leaving WAIT_PIN keeps fail count
        addVec(1'b0,1'b0,1'b1,1'b0,8'h38, 1'b0,1'b0,1'b0,1'b0,5'd2, 2'd0);
        addVec(1'b0,1'b0,1'b0,1'b0,8'h38, 1'b0,1'b0,1'b0,1'b0,5'd2, 2'd0);
        addVec(1'b1,1'b0,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b0,5'd2, 2'd0);
        addVec(1'b1,1'b0,1'b1,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b0,5'd2, 2'd1);
        addVec(1'b0,1'b0,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b0,5'd2, 2'd1);
        addVec(1'b0,1'b0,1'b1,1'b0,8'h38, 1'b0,1'b0,1'b0,1'b0,5'd2, 2'd1);
        addVec(1'b0,1'b0,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b0,5'd2, 2'd1);

        #5 reset = 1'b1;
        #15 reset = 1'b0;
        #1;
        chk("resetA", 32'(packA()), 32'(13'b0100_0000_00000));
        chk("resetB", 32'(packB()), 32'(10'b01_0000_0000));

        for (int i = 0; i < vecs.size(); i++) begin
            busA.sEntrada = vecs[i].ent;
            busA.sSalida  = vecs[i].sal;
            busA.sEnter   = vecs[i].en;
            busA.sVehSale = vecs[i].veh;
            busA.sCode    = vecs[i].code;
            @(posedge clock);
            #1;
            chk($sformatf("vecA[%0d]", i), 32'(packA()),
                32'({vecs[i].ab, ~vecs[i].ab, vecs[i].bl, vecs[i].bl, vecs[i].ai,
                     vecs[i].full, vecs[i].occ, vecs[i].fail}));
        end

        // capacity with CAP=2
        stepB(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        stepB(1'b1, 1'b0, 1'b1, 1'b0, 8'h38);
        chk("capOpen1", 32'(busB.sAbrir), 32'd1);
        stepB(1'b0, 1'b1, 1'b0, 1'b0, 8'h38);
        chk("capOcc1", 32'({busB.sFull, busB.occ}), 32'(3'b001));
        stepB(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        stepB(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        stepB(1'b1, 1'b0, 1'b1, 1'b0, 8'h38);
        chk("capOpen2", 32'(busB.sAbrir), 32'd1);
        stepB(1'b0, 1'b1, 1'b0, 1'b0, 8'h38);
        chk("capFull", 32'({busB.sFull, busB.occ}), 32'(3'b110));
        stepB(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        stepB(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        stepB(1'b1, 1'b0, 1'b1, 1'b0, 8'h38);
        chk("capHeldClosed", 32'({busB.sAbrir, busB.sCerrar, busB.fail_cnt}), 32'(4'b0100));
        stepB(1'b1, 1'b0, 1'b0, 1'b0, 8'h38);
        stepB(1'b1, 1'b0, 1'b0, 1'b1, 8'h38);
        chk("capLeave", 32'({busB.sAbrir, busB.sFull, busB.occ}), 32'(4'b0001));
        stepB(1'b1, 1'b0, 1'b0, 1'b0, 8'h38);
        stepB(1'b1, 1'b0, 1'b1, 1'b0, 8'h38);
        chk("capReopen", 32'(busB.sAbrir), 32'd1);
        stepB(1'b0, 1'b1, 1'b0, 1'b0, 8'h38);
        chk("capRefull", 32'({busB.sFull, busB.occ}), 32'(3'b110));
        stepB(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        // timeout with TMO_CYC=8
        stepB(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        stepB(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        stepB(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        stepB(1'b1, 1'b0, 1'b1, 1'b0, 8'h38);
        chk("tmoOpen", 32'({busB.sAbrir, busB.occ}), 32'(3'b101));
        for (int k = 0; k < 7; k++) begin
            stepB(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        end
        chk("tmoStillOpen7", 32'(busB.sAbrir), 32'd1);
        stepB(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("tmoClosed8", 32'({busB.sAbrir, busB.sCerrar, busB.occ}), 32'(4'b0101));

        // asynchronous reset while OPEN
        stepB(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        stepB(1'b1, 1'b0, 1'b1, 1'b0, 8'h38);
        chk("rstPreOpen", 32'(busB.sAbrir), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rstAsyncB", 32'(packB()), 32'(10'b01_0000_0000));
        chk("rstAsyncAocc", 32'(busA.occ), 32'd0);
        #2 reset = 1'b0;
        stepB(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("rstAfterIdle", 32'(packB()), 32'(10'b01_0000_0000));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/parking_gate_ctrl_p.md
Name: parking_gate_ctrl_p

Overview:
Parametrised parking-entrance gate controller, next generation of the fixed 8-bit-PIN gate FSM. Handles PIN entry with configurable width, code and attempt limit. Adds an open-gate timeout, a lot occupancy counter with a full flag, and the tailgating block/alarm. Sits between the entrance sensors/keypad and the gate actuator and alarm drivers.

Parameters:
PIN_W, 8, width of PIN code bus
PIN_OK, 8'b00111000, correct PIN (PIN_W bits)
MAX_FAIL, 3, wrong attempts before sAlmInc asserts
CAP, 16, lot capacity in vehicles
OCC_W, 5, occupancy counter width; must satisfy 2^OCC_W > CAP
TMO_CYC, 200, clock cycles the gate may stay open with no vehicle passage

Ports:
clock  in  1  single system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
sEntrada  in  1  vehicle-present sensor before gate
sSalida  in  1  vehicle-passed sensor after gate
sEnter  in  1  keypad enter, level; one attempt per rising edge
sCode  in  PIN_W  keypad code, sampled on the sEnter rising edge
sVehSale  in  1  vehicle leaving lot (exit lane); one decrement per rising edge
sAbrir  out  1  gate open command
sCerrar  out  1  gate close command (always equals ~sAbrir)
sBloq  out  1  controller in block state
sAlmInc  out  1  wrong-PIN alarm
sAlmBloq  out  1  tailgating alarm
sFull  out  1  occupancy == CAP
occ  out  OCC_W  current occupancy
fail_cnt  out  clog2(MAX_FAIL+1)  wrong attempts, saturating at MAX_FAIL

Behaviour:
- Reset values: state IDLE, sAbrir=0, sCerrar=1, sBloq=0, sAlmInc=0, sAlmBloq=0, sFull=0, occ=0, fail_cnt=0, timer=0, edge registers=0.
- All outputs are registered. An input sampled at edge N is reflected on outputs after edge N.
- enter_pulse = sEnter & ~sEnter_d. leave_pulse = sVehSale & ~sVehSale_d. pass_pulse = sSalida & ~sSalida_d. Each is a one-cycle internal strobe.
- States: IDLE, WAIT_PIN, OPEN, BLOCK.
- IDLE: sEntrada=1 -> WAIT_PIN. enter_pulse in IDLE is ignored.
- WAIT_PIN, on enter_pulse:
  - sCode==PIN_OK and !sFull -> OPEN. fail_cnt=0, sAlmInc=0.
  - sCode==PIN_OK and sFull -> stay in WAIT_PIN. fail_cnt and sAlmInc are still cleared. Gate stays closed.
  - sCode!=PIN_OK -> fail_cnt=min(fail_cnt+1, MAX_FAIL). sAlmInc=1 once fail_cnt reaches MAX_FAIL.
  - A correct PIN is still accepted while sAlmInc=1.
- WAIT_PIN: sEntrada falls to 0 with no pending accept -> IDLE. fail_cnt and sAlmInc are kept.
- OPEN:
  - sAbrir=1, sCerrar=0. Timer increments each cycle.
  - sEntrada=1 and sSalida=1 in the same cycle -> BLOCK. This check has priority over pass and timeout.
  - pass_pulse with sEntrada=0 -> IDLE. occ increments, saturating at CAP. Timer cleared.
  - Timer reaches TMO_CYC-1 -> IDLE. Gate closes, occ unchanged.
- BLOCK:
  - sAbrir=0, sCerrar=1, sBloq=1, sAlmBloq=1. Sensors are ignored.
  - Only a correct-PIN enter_pulse exits: -> OPEN, sBloq=0, sAlmBloq=0, timer=0, fail_cnt=0, sAlmInc=0.
  - A wrong PIN in BLOCK increments fail_cnt under the same rules as WAIT_PIN.
  - Exit is permitted even when sFull=1, since the vehicle is already committed.
- occ and sFull:
  - leave_pulse decrements occ, saturating at 0.
  - Same-cycle increment and decrement -> occ unchanged.
  - sFull = (occ_next == CAP), registered.
- Reset asserted mid-operation: immediate return to the reset values, including occ. Gate closes asynchronously.
- fail_cnt saturates and never wraps. Timer width is clog2(TMO_CYC).

Decomposition:
- Shared package gate_pkg: state encoding enum (IDLE=2'd0, WAIT_PIN=2'd1, OPEN=2'd2, BLOCK=2'd3) and the default PIN constant.
- One natural sub-module: gate_occ_counter. It holds the saturating up/down occupancy counter with the full flag, parametrised by CAP and OCC_W.
- The FSM, edge detectors and timer remain in parking_gate_ctrl_p.

Test Plan:
- Normal entry (10-unit clock): reset 5–20. sEntrada=1. sCode=0x38, sEnter pulse. Then sSalida=1 with sEntrada=0 -> sAbrir=1 one cycle after the enter edge, sCerrar=1 after the pass edge, occ=1.
- Two wrong PINs (0xDA, 0x0F), then 0x38 -> fail_cnt 1 then 2, sAlmInc stays 0, gate opens, fail_cnt returns to 0.
- Four wrong PINs (0x56, 0x6E, 0xFF, 0x01) -> sAlmInc=1 after the 3rd, fail_cnt holds at 3 on the 4th. Then 0x38 -> sAlmInc=0 and gate opens.
- Tailgate: gate open, {sEntrada,sSalida}=11 -> sBloq=sAlmBloq=1, sAbrir=0. Wrong PIN 0x7D keeps the block. 0x38 -> OPEN. Then sSalida pass -> close, occ increments.
- Capacity with CAP=2: two vehicles enter -> sFull=1. A third correct PIN -> gate stays closed. sVehSale pulse -> occ=1, sFull=0. Re-enter PIN -> gate opens.
- Timeout with TMO_CYC=8: correct PIN, no sSalida -> sAbrir falls exactly 8 cycles after opening, occ unchanged. Reset asserted while OPEN -> sAbrir=0 immediately and all outputs return to their reset values.
